// File: rtl/w5300_tx_scheduler.sv
// w5300_tx_scheduler: brings up the W5300 core from the config ROM, then
// arbitrates per-socket transmit requests. Each granted transfer gets one
// tx_req pulse to w5300_entry. The scheduler then follows busy_n to completion,
// with a per-phase timeout.
// Optional build macro: W5300_SCHED_STRICT_PRIO_EN selects fixed-priority
// arbitration (lowest index wins) in place of round-robin.
module w5300_tx_scheduler #(
  parameter int CHANNELS       = 4,
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 12,
  parameter int LEN_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int SOCK_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TMR_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNELS-1:0]             ch_req,
  input  logic [CHANNELS*LEN_WIDTH-1:0]   ch_len,
  input  logic [CHANNELS*DATA_WIDTH-1:0]  buf_data,
  output logic [ADDR_WIDTH-1:0]           buf_addr,
  input  logic [DATA_WIDTH-1:0]           conf_rom_data,
  output logic [ADDR_WIDTH-1:0]           conf_rom_addr,
  input  logic [ADDR_WIDTH-1:0]           core_tx_addr,
  output logic [DATA_WIDTH-1:0]           core_tx_data,
  input  logic                            core_busy_n,
  output logic                            core_tx_req,
  output logic [SOCK_W-1:0]               core_socket,
  output logic [LEN_WIDTH-1:0]            core_tx_len,
  output logic [CHANNELS-1:0]             ch_grant,
  output logic [CHANNELS-1:0]             ch_done,
  output logic                            tx_err,
  output logic                            ready
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_REQ  = 3'd2,
    S_ACK  = 3'd3,
    S_BUSY = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [SOCK_W-1:0]     r_sock;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [SOCK_W-1:0]     r_rr;
  logic                  r_seen;
  logic [TMR_W-1:0]      r_timer;

  logic                  w_found;
  logic [SOCK_W-1:0]     w_sel;
  logic [LEN_WIDTH-1:0]  w_sel_len;
  logic [SOCK_W-1:0]     w_rr_nx;
  logic                  w_tmo;
  logic                  w_load;
  logic                  w_seen_set;
  logic                  w_tmr_clr;
  logic                  w_tmr_inc;
  logic                  w_rr_adv;

  // Data path: the core address fans out to the ROM and every buffer; the read data comes back from the ROM during INIT and from the granted socket's buffer after that
  assign buf_addr      = core_tx_addr;
  assign conf_rom_addr = core_tx_addr;
  assign core_tx_data  = (r_state == S_INIT) ? conf_rom_data
                                             : buf_data[int'(r_sock)*DATA_WIDTH +: DATA_WIDTH];
  assign core_socket   = r_sock;
  assign core_tx_len   = r_len;

  assign w_tmo   = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_rr_nx = (r_sock == SOCK_W'(CHANNELS - 1)) ? '0 : r_sock + 1'b1;

  // Arbiter: first requesting channel scanning upward from the start index
  always_comb begin
    w_found   = 1'b0;
    w_sel     = '0;
    w_sel_len = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      logic [SOCK_W-1:0] idx;
`ifdef W5300_SCHED_STRICT_PRIO_EN
      idx = SOCK_W'(i);
`else
      idx = SOCK_W'((32'(r_rr) + i) % CHANNELS);
`endif
      if (!w_found && ch_req[idx]) begin
        w_found = 1'b1;
        w_sel   = idx;
      end
    end
    w_sel_len = ch_len[int'(w_sel)*LEN_WIDTH +: LEN_WIDTH];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_state_nx;
  end

  // Next-state and output decode
  always_comb begin
    w_state_nx  = r_state;
    core_tx_req = 1'b0;
    ch_grant    = '0;
    ch_done     = '0;
    tx_err      = 1'b0;
    ready       = 1'b0;
    w_load      = 1'b0;
    w_seen_set  = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_inc   = 1'b0;
    w_rr_adv    = 1'b0;
    case (r_state)
      S_INIT: begin
        if (!core_busy_n)  w_seen_set = 1'b1;
        else if (r_seen)   w_state_nx = S_IDLE;
      end
      S_IDLE: begin
        ready = 1'b1;
        if (w_found) begin
          ch_grant[w_sel] = 1'b1;
          w_load          = 1'b1;
          w_state_nx      = (w_sel_len == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        core_tx_req = 1'b1;
        w_tmr_clr   = 1'b1;
        w_state_nx  = S_ACK;
      end
      S_ACK: begin
        if (!core_busy_n) begin
          w_tmr_clr  = 1'b1;
          w_state_nx = S_BUSY;
        end else if (w_tmo) begin
          w_state_nx = S_ERR;
        end else begin
          w_tmr_inc  = 1'b1;
        end
      end
      S_BUSY: begin
        if (core_busy_n)  w_state_nx = S_DONE;
        else if (w_tmo)   w_state_nx = S_ERR;
        else              w_tmr_inc  = 1'b1;
      end
      S_DONE: begin
        ch_done[r_sock] = 1'b1;
        w_rr_adv        = 1'b1;
        w_state_nx      = S_IDLE;
      end
      S_ERR: begin
        ch_done[r_sock] = 1'b1;
        tx_err          = 1'b1;
        w_rr_adv        = 1'b1;
        w_state_nx      = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Transfer context, init handshake flag, timeout timer and arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sock  <= '0;
      r_len   <= '0;
      r_rr    <= '0;
      r_seen  <= 1'b0;
      r_timer <= '0;
    end else begin
      if (w_seen_set) r_seen <= 1'b1;
      if (w_load) begin
        r_sock <= w_sel;
        r_len  <= w_sel_len;
      end
      if (w_tmr_clr)      r_timer <= '0;
      else if (w_tmr_inc) r_timer <= r_timer + 1'b1;
`ifdef W5300_SCHED_STRICT_PRIO_EN
      r_rr <= '0;
`else
      if (w_rr_adv) r_rr <= w_rr_nx;
`endif
    end
  end

endmodule

// File: doc/w5300_tx_scheduler.md
Name: w5300_tx_scheduler

Overview:
Multi-channel successor to the top-level W5300 INIT/IDLE/BUSY sequencer. Sequences W5300 configuration, then arbitrates up to CHANNELS socket transmit requests. For each granted transfer it issues a single tx_req to w5300_entry and tracks busy_n to completion with a timeout. It also muxes the config ROM or the selected channel buffer onto the core tx data path. It sits between the per-socket UDP tx buffers and w5300_entry.

Parameters:
CHANNELS, 4, number of socket channels (1..8)
ADDR_WIDTH, 12, buffer/ROM address width
DATA_WIDTH, 12, buffer/ROM data width
LEN_WIDTH, 12, packet length field width (words)
TIMEOUT_CYCLES, 100000, max cycles waiting on core per transfer; width = $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  system clock (wclk0 domain)
rst_n  in  1  asynchronous active-low reset
ch_req  in  CHANNELS  per-channel send request, level, held until ch_grant
ch_len  in  CHANNELS*LEN_WIDTH  per-channel length, slice i = channel i, sampled at grant
buf_data  in  CHANNELS*DATA_WIDTH  per-channel tx buffer read data
buf_addr  out  ADDR_WIDTH  shared buffer read address
conf_rom_data  in  DATA_WIDTH  config ROM data
conf_rom_addr  out  ADDR_WIDTH  config ROM address
core_tx_addr  in  ADDR_WIDTH  read address from w5300_entry
core_tx_data  out  DATA_WIDTH  data to w5300_entry
core_busy_n  in  1  w5300_entry busy_n
core_tx_req  out  1  one-cycle transmit request pulse
core_socket  out  $clog2(CHANNELS) (min 1)  socket index of current transfer
core_tx_len  out  LEN_WIDTH  length of current transfer
ch_grant  out  CHANNELS  one-hot one-cycle grant pulse
ch_done  out  CHANNELS  one-hot one-cycle completion pulse
tx_err  out  1  one-cycle timeout pulse
ready  out  1  high in IDLE only

Behaviour:
- Reset (async, rst_n=0): state INIT, core_tx_req=0, ch_grant=0, ch_done=0, tx_err=0, core_socket=0, core_tx_len=0, ready=0, rr pointer=0, seen_busy=0, timer=0. Reset asserted mid-transfer aborts the transfer; no done or err pulse is issued.
- Data path (combinational): buf_addr = conf_rom_addr = core_tx_addr. core_tx_data = conf_rom_data in INIT, otherwise the buf_data slice at core_socket.
- States: INIT, IDLE, REQ, ACK, BUSY, DONE, ERR.
- INIT: sets seen_busy when core_busy_n=0. Goes to IDLE on the first cycle with core_busy_n=1 and seen_busy=1. A constant-high busy_n never leaves INIT; there is no timeout in INIT.
- IDLE: ready=1. When ch_req != 0, picks the first requesting channel at or after the rr pointer, wrapping modulo CHANNELS. In the same clock edge it registers core_socket=sel and core_tx_len=ch_len[sel] and pulses ch_grant[sel]. Next state is REQ, or DONE if the sampled length is 0.
- REQ: core_tx_req=1 for exactly this cycle. Timer cleared. Next state ACK.
- ACK: waits for core_busy_n=0, then goes to BUSY with the timer cleared.
- BUSY: waits for core_busy_n=1, then goes to DONE.
- Timer: increments every cycle in ACK and BUSY. Reaching TIMEOUT_CYCLES in either state goes to ERR.
- DONE: pulses ch_done[core_socket]. rr pointer = core_socket+1 mod CHANNELS. Next state IDLE.
- ERR: pulses tx_err and ch_done[core_socket]. rr pointer advances as in DONE. Next state IDLE.
- Grant-to-tx_req latency is 1 cycle. Minimum IDLE-to-IDLE time is 5 cycles: IDLE, REQ, ACK, BUSY, DONE, each with a 1-cycle core response.
- Requests arriving outside IDLE are not lost: ch_req is level and is re-evaluated on IDLE entry. A channel dropping ch_req before grant is simply not selected.
- Simultaneous requests are resolved by round-robin. A channel just served has the lowest priority on the next arbitration.
- core_socket and core_tx_len are held stable from grant until the next grant.
- Unused states decode to IDLE.

Optional Feature:
W5300_SCHED_STRICT_PRIO_EN: when defined, arbitration is fixed priority with the lowest index winning, and the rr pointer is unused (held 0). When undefined, round-robin as above. All other behaviour is identical.

Test Plan:
- Reset then busy_n 1→0 (10 cyc)→1 → INIT exits 1 cycle after busy_n rises; ready=1; core_tx_data tracks conf_rom_data in INIT and buf_data[0] after.
- ch_req=4'b0100, len[2]=64, core drops busy_n 2 cycles after tx_req and holds it 20 cycles → ch_grant=0100; next cycle core_tx_req=1, core_socket=2, core_tx_len=64; ch_done=0100 one cycle after busy_n rises.
- ch_req=4'b1111 held, core responds normally → grant order 0,1,2,3,0. With W5300_SCHED_STRICT_PRIO_EN: 0,0,0.
- Grant with ch_len=0 on channel 1 → ch_grant=0010, then ch_done=0010 next cycle, no core_tx_req.
- TIMEOUT_CYCLES=16, core never drops busy_n after tx_req → tx_err and ch_done[sel] pulse 16 cycles after entering ACK; return to IDLE.
- rst_n pulsed low in BUSY → all outputs return to reset values immediately; no ch_done/tx_err; re-enters INIT.
